demux_lane_scheduler: RTL and testbench

Byte-stream scheduler ahead of the 1x2 8-bit lane demux in the PCIe physical layer. Accepts a packetized byte stream with valid/ready and stripes it across two lanes: alternating bytes when both lanes are enabled, or all bytes to the single enabled lane. Pads odd-length packets in x2 mode so both lanes carry equal byte counts. Provides one registered output slot per lane with per-lane backpressure.

---
 rtl/demux_sched_pkg.sv | 29 ++
 rtl/demux_lane_scheduler_slot.sv | 35 +++
 rtl/demux_lane_scheduler.sv | 139 +++++++++++++
 tb/tb_demux_lane_scheduler.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/demux_sched_pkg.sv
// Shared types and encodings for the two-lane byte scheduler.
package demux_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_PAD    = 2'd2
  } state_t;

  localparam logic [1:0] CFG_OFF   = 2'b00;
  localparam logic [1:0] CFG_X1_L0 = 2'b01;
  localparam logic [1:0] CFG_X1_L1 = 2'b10;
  localparam logic [1:0] CFG_X2    = 2'b11;

  localparam logic [7:0] PAD_BYTE_DEFAULT = 8'hF7;

  // Lane a byte is steered to: the stripe pointer in x2, the enabled lane in x1.
  function automatic logic target_lane(input logic [1:0] cfg, input logic ptr);
    logic lane;
    case (cfg)
      CFG_X2:    lane = ptr;
      CFG_X1_L1: lane = 1'b1;
      CFG_X1_L0: lane = 1'b0;
      default:   lane = 1'b0;
    endcase
    return lane;
  endfunction

endpackage

// File: rtl/demux_lane_scheduler_slot.sv
// Single-entry registered output slot with valid/ready handshake.
module lane_out_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_free
);

  logic [DATA_W-1:0] r_data;
  logic              r_valid;

  // A load wins over a drain so the slot can turn over every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_free  = !r_valid || i_ready;

endmodule

// File: rtl/demux_lane_scheduler.sv
// Stripes a packetized byte stream across two lanes, padding odd x2 packets on lane 1.
module demux_lane_scheduler
  import demux_sched_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter logic [DATA_W-1:0] PAD_BYTE = PAD_BYTE_DEFAULT,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  input  logic [1:0]        lane_en,
  output logic [DATA_W-1:0] data_out0,
  output logic              outValid0,
  input  logic              ready0,
  output logic [DATA_W-1:0] data_out1,
  output logic              outValid1,
  input  logic              ready1,
  output logic              busy,
  output logic [CNT_W-1:0]  pkt_count,
  output logic [CNT_W-1:0]  pad_count
);

  state_t            r_state;
  logic              r_ptr;
  logic [1:0]        r_cfg;
  logic [CNT_W-1:0]  r_pkt_count;
  logic [CNT_W-1:0]  r_pad_count;

  logic [1:0]        w_eff_cfg;
  logic              w_x2;
  logic              w_tgt;
  logic              w_free0;
  logic              w_free1;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_load0;
  logic              w_load1;
  logic              w_pad_load;
  logic [DATA_W-1:0] w_data1;

  // Steering and handshake; lane_en is only honoured between packets.
  always_comb begin
    w_eff_cfg  = (r_state == ST_IDLE) ? lane_en : r_cfg;
    w_x2       = (w_eff_cfg == CFG_X2);
    w_tgt      = target_lane(w_eff_cfg, r_ptr);
    w_in_ready = (r_state != ST_PAD) && (w_eff_cfg != CFG_OFF) &&
                 (w_tgt ? w_free1 : w_free0);
    w_accept   = in_valid && w_in_ready;
    w_pad_load = (r_state == ST_PAD) && w_free1;
    w_load0    = w_accept && !w_tgt;
    w_load1    = (w_accept && w_tgt) || w_pad_load;
    w_data1    = w_pad_load ? PAD_BYTE : in_data;
  end

  // Packet state machine, stripe pointer and statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_ptr       <= 1'b0;
      r_cfg       <= CFG_OFF;
      r_pkt_count <= '0;
      r_pad_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_cfg <= lane_en;
            r_ptr <= w_x2 ? ~r_ptr : 1'b0;
            if (!in_last) begin
              r_state <= ST_ACTIVE;
            end else if (w_x2) begin
              r_state <= ST_PAD;
            end else begin
              r_pkt_count <= r_pkt_count + 1'b1;
            end
          end
        end
        ST_ACTIVE: begin
          if (w_accept) begin
            if (in_last && w_x2 && !w_tgt) begin
              r_state <= ST_PAD;
              r_ptr   <= 1'b1;
            end else if (in_last) begin
              r_state     <= ST_IDLE;
              r_ptr       <= 1'b0;
              r_pkt_count <= r_pkt_count + 1'b1;
            end else begin
              r_ptr <= w_x2 ? ~r_ptr : r_ptr;
            end
          end
        end
        ST_PAD: begin
          if (w_free1) begin
            r_state     <= ST_IDLE;
            r_ptr       <= 1'b0;
            r_pad_count <= r_pad_count + 1'b1;
            r_pkt_count <= r_pkt_count + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ptr   <= 1'b0;
        end
      endcase
    end
  end

  lane_out_slot #(.DATA_W(DATA_W)) u_slot0 (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load0),
    .i_data  (in_data),
    .i_ready (ready0),
    .o_data  (data_out0),
    .o_valid (outValid0),
    .o_free  (w_free0)
  );

  lane_out_slot #(.DATA_W(DATA_W)) u_slot1 (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load1),
    .i_data  (w_data1),
    .i_ready (ready1),
    .o_data  (data_out1),
    .o_valid (outValid1),
    .o_free  (w_free1)
  );

  assign in_ready  = w_in_ready;
  assign busy      = (r_state != ST_IDLE) || outValid0 || outValid1;
  assign pkt_count = r_pkt_count;
  assign pad_count = r_pad_count;

endmodule

// File: tb/tb_demux_lane_scheduler.sv
// Directed, table-driven bench for the two-lane byte scheduler.
module tb_demux_lane_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [1:0]  lane_en;
  logic [7:0]  data_out0;
  logic        outValid0;
  logic        ready0;
  logic [7:0]  data_out1;
  logic        outValid1;
  logic        ready1;
  logic        busy;
  logic [15:0] pkt_count;
  logic [15:0] pad_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  demux_lane_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .lane_en   (lane_en),
    .data_out0 (data_out0),
    .outValid0 (outValid0),
    .ready0    (ready0),
    .data_out1 (data_out1),
    .outValid1 (outValid1),
    .ready1    (ready1),
    .busy      (busy),
    .pkt_count (pkt_count),
    .pad_count (pad_count)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  en;
    logic        vld;
    logic        lst;
    logic [7:0]  dat;
    logic        r0;
    logic        r1;
    logic        rdy;
    logic        v0;
    logic [7:0]  d0;
    logic        v1;
    logic [7:0]  d1;
    logic [15:0] pkt;
    logic [15:0] pad;
    logic        bsy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic [1:0] en, input logic vld,
                              input logic lst, input logic [7:0] dat, input logic r0,
                              input logic r1, input logic rdy, input logic v0,
                              input logic [7:0] d0, input logic v1, input logic [7:0] d1,
                              input logic [15:0] pkt, input logic [15:0] pad,
                              input logic bsy);
    vec_t t;
    t.rst = rst; t.en = en; t.vld = vld; t.lst = lst; t.dat = dat;
    t.r0 = r0; t.r1 = r1; t.rdy = rdy; t.v0 = v0; t.d0 = d0;
    t.v1 = v1; t.d1 = d1; t.pkt = pkt; t.pad = pad; t.bsy = bsy;
    return t;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at vector %0d: got %h, want %h", nm, idx, act, exp);
    end
  endtask

  // Drive one vector, check in_ready before the edge and registered outputs after it.
  task automatic apply(input vec_t t, input int idx);
    @(negedge clk);
    reset = t.rst; lane_en = t.en; in_valid = t.vld; in_last = t.lst;
    in_data = t.dat; ready0 = t.r0; ready1 = t.r1;
    #1;
    n_vec++;
    chk("in_ready", idx, {31'd0, in_ready}, {31'd0, t.rdy});
    @(posedge clk);
    #1;
    chk("outValid0", idx, {31'd0, outValid0}, {31'd0, t.v0});
    chk("data_out0", idx, {24'd0, data_out0}, {24'd0, t.d0});
    chk("outValid1", idx, {31'd0, outValid1}, {31'd0, t.v1});
    chk("data_out1", idx, {24'd0, data_out1}, {24'd0, t.d1});
    chk("pkt_count", idx, {16'd0, pkt_count}, {16'd0, t.pkt});
    chk("pad_count", idx, {16'd0, pad_count}, {16'd0, t.pad});
    chk("busy",      idx, {31'd0, busy},      {31'd0, t.bsy});
  endtask

  initial begin
    //                 rst  en     vld   lst   dat    r0    r1    rdy   v0    d0     v1    d1     pkt    pad    bsy
    // x2 even packet
    tbl.push_back(mk(1'b0,2'b11,1'b1,1'b0,8'h11,1'b1,1'b1,1'b1,1'b1,8'h11,1'b0,8'h00,16'd0,16'd0,1'b1));
    tbl.push_back(mk(1'b0,2'b11,1'b1,1'b0,8'h22,1'b1,1'b1,1'b1,1'b0,8'h11,1'b1,8'h22,16'd0,16'd0,1'b1));
    tbl.push_back(mk(1'b0,2'b11,1'b1,1'b0,8'h33,1'b1,1'b1,1'b1,1'b1,8'h33,1'b0,8'h22,16'd0,16'd0,1'b1));
    tbl.push_back(mk(1'b0,2'b11,1'b1,1'b1,8'h44,1'b1,1'b1,1'b1,1'b0,8'h33,1'b1,8'h44,16'd1,16'd0,1'b1));
    tbl.push_back(mk(1'b0,2'b11,1'b0,1'b0,8'h00,1'b1,1'b1,1'b1,1'b0,8'h33,1'b0,8'h44,16'd1,16'd0,1'b0));
    // x2 odd packet, pad on lane 1
    tbl.push_back(mk(1'b0,2'b11,1'b1,1'b0,8'hA1,1'b1,1'b1,1'b1,1'b1,8'hA1,1'b0,8'h44,16'd1,16'd0,1'b1));
    tbl.push_back(mk(1'b0,2'b11,1'b1,1'b0,8'hB2,1'b1,1'b1,1'b1,1'b0,8'hA1,1'b1,8'hB2,16'd1,16'd0,1'b1));
    tbl.push_back(mk(1'b0,2'b11,1'b1,1'b1,8'hC3,1'b1,1'b1,1'b1,1'b1,8'hC3,1'b0,8'hB2,16'd1,16'd0,1'b1));
    tbl.push_back(mk(1'b0,2'b11,1'b0,1'b0,8'h00,1'b1,1'b1,1'b0,1'b0,8'hC3,1'b1,8'hF7,16'd2,16'd1,1'b1));
    tbl.push_back(mk(1'b0,2'b11,1'b0,1'b0,8'h00,1'b1,1'b1,1'b1,1'b0,8'hC3,1'b0,8'hF7,16'd2,16'd1,1'b0));
    // x1 on lane 1
    tbl.push_back(mk(1'b0,2'b10,1'b1,1'b0,8'h5A,1'b1,1'b1,1'b1,1'b0,8'hC3,1'b1,8'h5A,16'd2,16'd1,1'b1));
    tbl.push_back(mk(1'b0,2'b10,1'b1,1'b0,8'h6B,1'b1,1'b1,1'b1,1'b0,8'hC3,1'b1,8'h6B,16'd2,16'd1,1'b1));
    tbl.push_back(mk(1'b0,2'b10,1'b1,1'b1,8'h7C,1'b1,1'b1,1'b1,1'b0,8'hC3,1'b1,8'h7C,16'd3,16'd1,1'b1));
    tbl.push_back(mk(1'b0,2'b10,1'b0,1'b0,8'h00,1'b1,1'b1,1'b1,1'b0,8'hC3,1'b0,8'h7C,16'd3,16'd1,1'b0));
    // x2 with lane 1 stalled for five cycles
    tbl.push_back(mk(1'b0,2'b11,1'b1,1'b0,8'h10,1'b1,1'b1,1'b1,1'b1,8'h10,1'b0,8'h7C,16'd3,16'd1,1'b1));
    tbl.push_back(mk(1'b0,2'b11,1'b1,1'b0,8'h20,1'b1,1'b0,1'b1,1'b0,8'h10,1'b1,8'h20,16'd3,16'd1,1'b1));
    tbl.push_back(mk(1'b0,2'b11,1'b1,1'b0,8'h30,1'b1,1'b0,1'b1,1'b1,8'h30,1'b1,8'h20,16'd3,16'd1,1'b1));
    tbl.push_back(mk(1'b0,2'b11,1'b1,1'b0,8'h40,1'b1,1'b0,1'b0,1'b0,8'h30,1'b1,8'h20,16'd3,16'd1,1'b1));
    tbl.push_back(mk(1'b0,2'b11,1'b1,1'b0,8'h40,1'b1,1'b0,1'b0,1'b0,8'h30,1'b1,8'h20,16'd3,16'd1,1'b1));
    tbl.push_back(mk(1'b0,2'b11,1'b1,1'b0,8'h40,1'b1,1'b0,1'b0,1'b0,8'h30,1'b1,8'h20,16'd3,16'd1,1'b1));
    tbl.push_back(mk(1'b0,2'b11,1'b1,1'b0,8'h40,1'b1,1'b1,1'b1,1'b0,8'h30,1'b1,8'h40,16'd3,16'd1,1'b1));
    tbl.push_back(mk(1'b0,2'b11,1'b1,1'b0,8'h50,1'b1,1'b1,1'b1,1'b1,8'h50,1'b0,8'h40,16'd3,16'd1,1'b1));
    tbl.push_back(mk(1'b0,2'b11,1'b1,1'b1,8'h60,1'b1,1'b1,1'b1,1'b0,8'h50,1'b1,8'h60,16'd4,16'd1,1'b1));
    tbl.push_back(mk(1'b0,2'b11,1'b0,1'b0,8'h00,1'b1,1'b1,1'b1,1'b0,8'h50,1'b0,8'h60,16'd4,16'd1,1'b0));
    // lane_en 11 -> 01 mid-packet, then x1 lane 0, then lanes off
    tbl.push_back(mk(1'b0,2'b11,1'b1,1'b0,8'h81,1'b1,1'b1,1'b1,1'b1,8'h81,1'b0,8'h60,16'd4,16'd1,1'b1));
    tbl.push_back(mk(1'b0,2'b01,1'b1,1'b0,8'h82,1'b1,1'b1,1'b1,1'b0,8'h81,1'b1,8'h82,16'd4,16'd1,1'b1));
    tbl.push_back(mk(1'b0,2'b01,1'b1,1'b0,8'h83,1'b1,1'b1,1'b1,1'b1,8'h83,1'b0,8'h82,16'd4,16'd1,1'b1));
    tbl.push_back(mk(1'b0,2'b01,1'b1,1'b1,8'h84,1'b1,1'b1,1'b1,1'b0,8'h83,1'b1,8'h84,16'd5,16'd1,1'b1));
    tbl.push_back(mk(1'b0,2'b01,1'b1,1'b1,8'h91,1'b1,1'b1,1'b1,1'b1,8'h91,1'b0,8'h84,16'd6,16'd1,1'b1));
    tbl.push_back(mk(1'b0,2'b01,1'b1,1'b0,8'h92,1'b1,1'b1,1'b1,1'b1,8'h92,1'b0,8'h84,16'd6,16'd1,1'b1));
    tbl.push_back(mk(1'b0,2'b01,1'b1,1'b1,8'h93,1'b1,1'b1,1'b1,1'b1,8'h93,1'b0,8'h84,16'd7,16'd1,1'b1));
    tbl.push_back(mk(1'b0,2'b00,1'b1,1'b0,8'hAA,1'b1,1'b1,1'b0,1'b0,8'h93,1'b0,8'h84,16'd7,16'd1,1'b0));
    tbl.push_back(mk(1'b0,2'b00,1'b1,1'b0,8'hAA,1'b1,1'b1,1'b0,1'b0,8'h93,1'b0,8'h84,16'd7,16'd1,1'b0));
    // in_last without in_valid is ignored
    tbl.push_back(mk(1'b0,2'b11,1'b0,1'b1,8'hBB,1'b1,1'b1,1'b1,1'b0,8'h93,1'b0,8'h84,16'd7,16'd1,1'b0));
    // reach PAD with slot 1 stuck full, then reset
    tbl.push_back(mk(1'b0,2'b11,1'b1,1'b0,8'hC1,1'b1,1'b0,1'b1,1'b1,8'hC1,1'b0,8'h84,16'd7,16'd1,1'b1));
    tbl.push_back(mk(1'b0,2'b11,1'b1,1'b0,8'hC2,1'b1,1'b0,1'b1,1'b0,8'hC1,1'b1,8'hC2,16'd7,16'd1,1'b1));
    tbl.push_back(mk(1'b0,2'b11,1'b1,1'b1,8'hC3,1'b1,1'b0,1'b1,1'b1,8'hC3,1'b1,8'hC2,16'd7,16'd1,1'b1));
    tbl.push_back(mk(1'b0,2'b11,1'b0,1'b0,8'h00,1'b1,1'b0,1'b0,1'b0,8'hC3,1'b1,8'hC2,16'd7,16'd1,1'b1));
    tbl.push_back(mk(1'b1,2'b11,1'b0,1'b0,8'h00,1'b1,1'b0,1'b0,1'b0,8'h00,1'b0,8'h00,16'd0,16'd0,1'b0));
    tbl.push_back(mk(1'b0,2'b11,1'b0,1'b0,8'h00,1'b1,1'b1,1'b1,1'b0,8'h00,1'b0,8'h00,16'd0,16'd0,1'b0));
    // single-byte x2 packet: starts on lane 0, padded
    tbl.push_back(mk(1'b0,2'b11,1'b1,1'b1,8'hE1,1'b1,1'b1,1'b1,1'b1,8'hE1,1'b0,8'h00,16'd0,16'd0,1'b1));
    tbl.push_back(mk(1'b0,2'b11,1'b0,1'b0,8'h00,1'b1,1'b1,1'b0,1'b0,8'hE1,1'b1,8'hF7,16'd1,16'd1,1'b1));

    reset = 1'b1; lane_en = 2'b11; in_valid = 1'b0; in_last = 1'b0;
    in_data = 8'h00; ready0 = 1'b1; ready1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    chk("reset outValid0", 0, {31'd0, outValid0}, 32'd0);
    chk("reset outValid1", 0, {31'd0, outValid1}, 32'd0);
    chk("reset data_out0", 0, {24'd0, data_out0}, 32'd0);
    chk("reset data_out1", 0, {24'd0, data_out1}, 32'd0);
    chk("reset pkt_count", 0, {16'd0, pkt_count}, 32'd0);
    chk("reset pad_count", 0, {16'd0, pad_count}, 32'd0);
    chk("reset busy",      0, {31'd0, busy},      32'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], i + 1);
    end

    // Lanes disabled with data pending: must stall for as long as it lasts.
    for (int k = 0; k < 6; k++) begin
      apply(mk(1'b0,2'b00,1'b1,1'b1,8'h5C,1'b1,1'b1,1'b0,1'b0,8'hE1,1'b0,8'hF7,16'd1,16'd1,1'b0),
            100 + k);
    end
    // Re-enabling lane 0 releases the stalled byte as a one-byte packet.
    apply(mk(1'b0,2'b01,1'b1,1'b1,8'h5C,1'b1,1'b1,1'b1,1'b1,8'h5C,1'b0,8'hF7,16'd2,16'd1,1'b1), 106);
    apply(mk(1'b0,2'b01,1'b0,1'b0,8'h00,1'b0,1'b1,1'b0,1'b1,8'h5C,1'b0,8'hF7,16'd2,16'd1,1'b1), 107);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
